// File: rtl/monochrome_ctrl.sv
// -----------------------------------------------------------------------------
// monochrome_ctrl
//
// Holds the monochrome conversion mode (0 colour, 1 green, 2 amber, 3 grey) in a
// ZX-Uno register. The mode can be written through the register or stepped by a
// hotkey pulse. Requests are parked as "pending" and committed only at the start
// of vertical sync, so a frame is never rendered in two modes. Each commit
// starts an OSD banner that lasts OSD_FRAMES vsync starts.
//
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   zxuno_addr           selected ZX-Uno register address
//   zxuno_regrd          register read strobe
//   zxuno_regwr          register write strobe (one-cycle pulse)
//   din                  register write data (only din[1:0] is used)
//   dout, oe             read data {pending, 5'b0, next mode} and its enable
//   hotkey_cycle         one-cycle pulse requesting the next mode
//   vsync                vertical sync, polarity set by VSYNC_POL
//   monochrome_selection committed mode for the datapath (registered)
//   osd_show             OSD banner visible (registered)
//   osd_mode             mode shown in the banner, same as the committed mode
// -----------------------------------------------------------------------------
module monochrome_ctrl #(
  parameter logic [7:0] ADDR       = 8'h0D,
  parameter logic       VSYNC_POL  = 1'b0,
  parameter logic [7:0] OSD_FRAMES = 8'd50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe,
  input  logic       hotkey_cycle,
  input  logic       vsync,
  output logic [1:0] monochrome_selection,
  output logic       osd_show,
  output logic [1:0] osd_mode
);

  logic [1:0] active;
  logic [1:0] pend_mode;
  logic       pending;
  logic [7:0] osd_cnt;
  logic [7:0] osd_cnt_nxt;
  logic       vs_q;
  logic       vs_qq;
  logic       osd_show_q;

  logic       vs_start;
  logic       commit;
  logic       wr_hit;
  logic [1:0] next_mode;

  // vs_q/vs_qq are normalised to active-high, so a rising edge is a vsync start.
  assign vs_start  = vs_q & ~vs_qq;
  assign commit    = vs_start & pending;
  assign wr_hit    = zxuno_regwr & (zxuno_addr == ADDR);
  // Mode that will be in effect after the next commit.
  assign next_mode = pending ? pend_mode : active;

  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, otherwise
    // a path that skips the assignment infers a latch.
    osd_cnt_nxt = osd_cnt;
    if (commit) begin
      osd_cnt_nxt = OSD_FRAMES;
    end else if (vs_start && (osd_cnt != 8'd0)) begin
      osd_cnt_nxt = osd_cnt - 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every right-hand
  // side sees pre-edge values; the hotkey's next_mode and the commit's
  // pend_mode both rely on that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active     <= 2'd0;
      pend_mode  <= 2'd0;
      pending    <= 1'b0;
      osd_cnt    <= 8'd0;
      osd_show_q <= 1'b0;
      vs_q       <= 1'b0;
      vs_qq      <= 1'b0;
    end else begin
      vs_q       <= (vsync == VSYNC_POL);
      vs_qq      <= vs_q;
      osd_cnt    <= osd_cnt_nxt;
      osd_show_q <= (osd_cnt_nxt != 8'd0);

      if (commit) begin
        active  <= pend_mode;
        pending <= 1'b0;
      end

      // NOTE: a request in the commit cycle is placed after the commit so its
      // pending <= 1 overrides the clear; the last non-blocking write wins.
      if (wr_hit) begin
        pend_mode <= din[1:0];
        pending   <= 1'b1;
      end else if (hotkey_cycle) begin
        pend_mode <= next_mode + 2'd1;
        pending   <= 1'b1;
      end
    end
  end

  assign monochrome_selection = active;
  assign osd_mode             = active;
  assign osd_show             = osd_show_q;

  assign oe   = zxuno_regrd & (zxuno_addr == ADDR);
  assign dout = oe ? {pending, 5'b00000, next_mode} : 8'h00;

endmodule
